oam_dma: RTL and testbench

OAM DMA engine for the graphics subsystem. A CPU write to the DMA register (0xFF46) makes the engine take the system bus as initiator and copy 160 bytes from `{src_hi, 8'h00}..{src_hi, 8'h9F}` into OAM (0xFE00..0xFE9F). It is the initiator side of the same byte bus the video peripheral answers on. It sits beside the CPU and requests bus ownership through a req/grant handshake with the arbiter.

---
 rtl/video_types.sv | 21 ++
 rtl/oam_dma.sv | 136 +++++++++++++
 tb/tb_oam_dma.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_types.sv
// Shared graphics-subsystem types: OAM geometry, DMA register address and the DMA state set.
package video_types;

  localparam logic [15:0] OAM_LOC      = 16'hFE00;
  localparam int          OAM_SIZE     = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    CAP,
    WR
  } dma_state_t;

  // Sources in echo RAM (0xE0xx and up) alias work RAM 0x2000 lower.
  function automatic logic [7:0] echo_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? hi - 8'h20 : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: copies XFER_LEN bytes from {src_hi,00} into OAM over the shared byte bus.
// Optional completion pulse output done_irq when OAM_DMA_DONE_IRQ_EN is defined.
module oam_dma
  import video_types::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = video_types::DMA_REG_ADDR,
  parameter logic [15:0] OAM_BASE     = video_types::OAM_LOC,
  parameter int          XFER_LEN     = video_types::OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_addr,
  input  logic [7:0]  s_wdata,
  input  logic        s_rd,
  input  logic        s_wr,
  output logic [7:0]  s_rdata,
  output logic        s_rdata_en,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [7:0]  m_rdata,
  output logic        busy
`ifdef OAM_DMA_DONE_IRQ_EN
  ,
  output logic        done_irq
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic [7:0] src_hi;
  logic [7:0] src_eff;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic       reg_hit_wr;
  logic       reg_hit_rd;

  assign src_eff    = echo_map(src_hi);
  assign reg_hit_wr = s_wr && (s_addr == DMA_REG_ADDR);
  assign reg_hit_rd = s_rd && (s_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rdata    <= 8'h00;
      s_rdata_en <= 1'b0;
    end else begin
      s_rdata_en <= reg_hit_rd;
      if (reg_hit_rd) s_rdata <= src_hi;
    end
  end

  // Strobes are registered: the grant seen at an edge decides whether the
  // next cycle carries a strobe, so each low-grant edge costs exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      src_hi   <= 8'h00;
      idx      <= 8'h00;
      data_q   <= 8'h00;
      bus_req  <= 1'b0;
      busy     <= 1'b0;
      m_addr   <= 16'h0000;
      m_wdata  <= 8'h00;
      m_rd     <= 1'b0;
      m_wr     <= 1'b0;
`ifdef OAM_DMA_DONE_IRQ_EN
      done_irq <= 1'b0;
`endif
    end else begin
      m_rd     <= 1'b0;
      m_wr     <= 1'b0;
`ifdef OAM_DMA_DONE_IRQ_EN
      done_irq <= 1'b0;
`endif
      if (reg_hit_wr) begin
        src_hi  <= s_wdata;
        idx     <= 8'h00;
        state   <= REQ;
        busy    <= 1'b1;
        bus_req <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          REQ: begin
            if (bus_gnt) begin
              state  <= RD;
              m_rd   <= 1'b1;
              m_addr <= {src_eff, idx};
            end
          end
          RD: begin
            if (m_rd) begin
              state <= CAP;
            end else if (bus_gnt) begin
              m_rd   <= 1'b1;
              m_addr <= {src_eff, idx};
            end
          end
          CAP: begin
            data_q  <= m_rdata;
            m_wdata <= m_rdata;
            m_addr  <= OAM_BASE + {8'h00, idx};
            m_wr    <= bus_gnt;
            state   <= WR;
          end
          WR: begin
            if (m_wr) begin
              if (idx == LAST_IDX) begin
                state    <= IDLE;
                busy     <= 1'b0;
                bus_req  <= 1'b0;
`ifdef OAM_DMA_DONE_IRQ_EN
                done_irq <= 1'b1;
`endif
              end else begin
                idx    <= idx + 8'd1;
                state  <= RD;
                m_rd   <= bus_gnt;
                m_addr <= {src_eff, idx + 8'd1};
              end
            end else if (bus_gnt) begin
              m_wr    <= 1'b1;
              m_wdata <= data_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: transaction-level model of the copy plus directed and random transfers.
// Counts done_irq pulses when OAM_DMA_DONE_IRQ_EN is defined.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_addr = 16'h0000;
  logic [7:0]  s_wdata = 8'h00;
  logic        s_rd = 1'b0;
  logic        s_wr = 1'b0;
  logic [7:0]  s_rdata;
  logic        s_rdata_en;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [7:0]  m_rdata = 8'h00;
  logic        busy;
`ifdef OAM_DMA_DONE_IRQ_EN
  logic        done_irq;
  int          irqCount = 0;
  int          irq0 = 0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model of the copy: which page is being read and which byte/phase comes next.
  bit          active = 1'b0;
  logic [7:0]  expPage = 8'h00;
  int          expK = 0;
  bit          expWrPhase = 1'b0;
  bit          firstSeen = 1'b0;
  logic [15:0] firstRdAddr = 16'h0000;
  logic [15:0] lastWrAddr = 16'h0000;
  logic        prevGnt = 1'b1;
  logic [7:0]  oam [160];

  always #5 clk = ~clk;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rd       (s_rd),
    .s_wr       (s_wr),
    .s_rdata    (s_rdata),
    .s_rdata_en (s_rdata_en),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_rdata    (m_rdata),
    .busy       (busy)
`ifdef OAM_DMA_DONE_IRQ_EN
    ,
    .done_irq   (done_irq)
`endif
  );

  function automatic logic [7:0] memByte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
  endfunction

  function automatic logic [7:0] effPage(input logic [7:0] s);
    if (s >= 8'hE0) return s - 8'h20;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Source memory: answers a read strobe with data valid the following cycle.
  always @(posedge clk) m_rdata <= m_rd ? memByte(m_addr) : 8'($urandom);

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("req_eq_busy", {31'd0, bus_req}, {31'd0, busy});
      checkOutput("rd_wr_exclusive", {31'd0, m_rd & m_wr}, 32'd0);
      if (m_rd || m_wr) begin
        checkOutput("strobe_after_gnt", {31'd0, prevGnt}, 32'd1);
        checkOutput("strobe_expected", {31'd0, active}, 32'd1);
        if (active && m_rd) begin
          checkOutput("rd_phase", {31'd0, expWrPhase}, 32'd0);
          checkOutput("rd_addr", {16'd0, m_addr}, {16'd0, expPage, 8'(expK)});
          if (!firstSeen) firstRdAddr = m_addr;
          firstSeen  = 1'b1;
          expWrPhase = 1'b1;
        end else if (active && m_wr) begin
          checkOutput("wr_phase", {31'd0, expWrPhase}, 32'd1);
          checkOutput("wr_addr", {16'd0, m_addr}, 32'hFE00 + expK);
          checkOutput("wr_data", {24'd0, m_wdata}, {24'd0, memByte({expPage, 8'(expK)})});
          lastWrAddr = m_addr;
          expWrPhase = 1'b0;
          expK++;
          if (expK == 160) active = 1'b0;
        end
        if (m_wr && m_addr >= 16'hFE00 && m_addr < 16'hFEA0) oam[m_addr - 16'hFE00] = m_wdata;
      end
`ifdef OAM_DMA_DONE_IRQ_EN
      if (done_irq === 1'b1) irqCount++;
`endif
    end
    prevGnt = bus_gnt;
  end

  // Register write; a hit on 0xFF46 restarts the model once the DUT has sampled it.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
    s_addr  = addr;
    s_wdata = data;
    s_wr    = 1'b1;
    @(posedge clk); #1;
    s_wr = 1'b0;
    if (addr == 16'hFF46) begin
      active     = 1'b1;
      expPage    = effPage(data);
      expK       = 0;
      expWrPhase = 1'b0;
      firstSeen  = 1'b0;
    end
  endtask

  task automatic readReg(input logic [15:0] addr, input bit expEn, input logic [7:0] expData, input string tag);
    s_addr = addr;
    s_rd   = 1'b1;
    @(posedge clk); #1;
    s_rd = 1'b0;
    checkOutput({tag, "_en"}, {31'd0, s_rdata_en}, {31'd0, expEn});
    if (expEn) checkOutput({tag, "_data"}, {24'd0, s_rdata}, {24'd0, expData});
  endtask

  task automatic waitDone(input int startCount, input int expLen, input bit randGnt, input string tag);
    int n = startCount;
    while (busy && n < 5000) begin
      if (randGnt) bus_gnt = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    bus_gnt = 1'b1;
    checkOutput({tag, "_done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_all_bytes"}, expK, 32'd160);
    if (expLen > 0) checkOutput({tag, "_len"}, n, expLen);
  endtask

  task automatic waitStrobe(input bit wantWr, input logic [15:0] addr, output int n);
    n = 0;
    while (!((wantWr ? m_wr : m_rd) && m_addr == addr) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_strobe", {16'd0, m_addr}, {16'd0, addr});
  endtask

  task automatic clearOam();
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
  endtask

  task automatic checkOam(input logic [7:0] page, input string tag);
    for (int k = 0; k < 160; k++)
      checkOutput(tag, {24'd0, oam[k]}, {24'd0, memByte({page, 8'(k)})});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_rdata"}, {24'd0, s_rdata}, 32'd0);
    checkOutput({tag, "_s_rdata_en"}, {31'd0, s_rdata_en}, 32'd0);
    checkOutput({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    checkOutput({tag, "_m_addr"}, {16'd0, m_addr}, 32'd0);
    checkOutput({tag, "_m_wdata"}, {24'd0, m_wdata}, 32'd0);
    checkOutput({tag, "_m_rd"}, {31'd0, m_rd}, 32'd0);
    checkOutput({tag, "_m_wr"}, {31'd0, m_wr}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    logic [7:0]  rv;

    clearOam();
    repeat (2) @(posedge clk);
    #1 checkResetValues("init");
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Plain transfer from 0xC0 with the grant held.
    clearOam();
`ifdef OAM_DMA_DONE_IRQ_EN
    irq0 = irqCount;
`endif
    applyStimulus(16'hFF46, 8'hC0);
    checkOutput("t1_busy_n1", {31'd0, busy}, 32'd1);
    checkOutput("t1_req_n1", {31'd0, bus_req}, 32'd1);
    checkOutput("t1_rd_n1", {31'd0, m_rd}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_rd_n2", {31'd0, m_rd}, 32'd1);
    checkOutput("t1_first_rd_addr", {16'd0, m_addr}, 32'hC000);
    waitDone(1, 481, 1'b0, "t1");
    checkOutput("t1_last_wr_addr", {16'd0, lastWrAddr}, 32'hFE9F);
    checkOutput("t1_oam0", {24'd0, oam[0]}, 32'h5A);
    checkOutput("t1_oam159", {24'd0, oam[159]}, 32'hC5);
    checkOam(8'hC0, "t1_oam");
`ifdef OAM_DMA_DONE_IRQ_EN
    checkOutput("t1_irq_pulses", irqCount - irq0, 32'd1);
`endif

    // Echo-RAM source.
    clearOam();
    applyStimulus(16'hFF46, 8'hE1);
    waitDone(0, 481, 1'b0, "t2");
    checkOutput("t2_first_rd_addr", {16'd0, firstRdAddr}, 32'hC100);
    checkOam(8'hC1, "t2_oam");
    readReg(16'hFF46, 1'b1, 8'hE1, "t2_readback");

    // Grant dropped for 10 cycles just before byte 50's read.
    clearOam();
    applyStimulus(16'hFF46, 8'hC0);
    waitStrobe(1'b1, 16'hFE31, n);
    bus_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      checkOutput("t3_no_strobe_in_drop", {31'd0, m_rd | m_wr}, 32'd0);
    end
    bus_gnt = 1'b1;
    waitDone(n, 491, 1'b0, "t3");
    checkOam(8'hC0, "t3_oam");

    // Retrigger with 0xD0 during byte 80's read.
    clearOam();
`ifdef OAM_DMA_DONE_IRQ_EN
    irq0 = irqCount;
`endif
    applyStimulus(16'hFF46, 8'hC0);
    waitStrobe(1'b0, 16'hC050, n);
    applyStimulus(16'hFF46, 8'hD0);
    checkOutput("t4_busy", {31'd0, busy}, 32'd1);
    checkOutput("t4_no_old_strobe", {31'd0, m_rd | m_wr}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t4_rd", {31'd0, m_rd}, 32'd1);
    checkOutput("t4_rd_addr", {16'd0, m_addr}, 32'hD000);
    waitDone(1, 481, 1'b0, "t4");
    checkOam(8'hD0, "t4_oam");
`ifdef OAM_DMA_DONE_IRQ_EN
    checkOutput("t4_irq_pulses", irqCount - irq0, 32'd1);
`endif

    // Reset in the middle of byte 30.
`ifdef OAM_DMA_DONE_IRQ_EN
    irq0 = irqCount;
`endif
    applyStimulus(16'hFF46, 8'hC0);
    waitStrobe(1'b0, 16'hC01E, n);
    #1 reset = 1'b1;
    active = 1'b0;
    #1 checkResetValues("t5");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("t5_idle_after_reset", {30'd0, busy, m_rd | m_wr}, 32'd0);
    end
    readReg(16'hFF46, 1'b1, 8'h00, "t5_readback");
`ifdef OAM_DMA_DONE_IRQ_EN
    checkOutput("t5_irq_pulses", irqCount - irq0, 32'd0);
`endif

    // Random pages, random grant activity, stray register traffic.
    for (int t = 0; t < 4; t++) begin
      ra = 16'($urandom);
      if (ra == 16'hFF46) ra = 16'hFF47;
      applyStimulus(ra, 8'($urandom));
      checkOutput("rand_no_trigger", {31'd0, busy}, 32'd0);
      readReg(ra, 1'b0, 8'h00, "rand_other_read");
      rv = 8'($urandom);
      clearOam();
`ifdef OAM_DMA_DONE_IRQ_EN
      irq0 = irqCount;
`endif
      applyStimulus(16'hFF46, rv);
      waitDone(0, -1, 1'b1, "rand");
      checkOam(effPage(rv), "rand_oam");
      readReg(16'hFF46, 1'b1, rv, "rand_readback");
`ifdef OAM_DMA_DONE_IRQ_EN
      checkOutput("rand_irq_pulses", irqCount - irq0, 32'd1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
